// File: rtl/apb_req_arbiter.sv
// Two-client arbiter/sequencer driving the APB master command inputs.
// Define APB_ARB_FIXED_PRIO_EN for fixed priority (client 0 wins); default is round-robin.
module apb_req_arbiter #(
   parameter int AW = 8,
   parameter int DW = 8
) (
   input  logic          pclk,
   input  logic          preset,
   input  logic [1:0]    req,
   input  logic [1:0]    req_wr,
   input  logic [AW-1:0] req_addr0,
   input  logic [AW-1:0] req_addr1,
   input  logic [DW-1:0] req_wdata0,
   input  logic [DW-1:0] req_wdata1,
   output logic [1:0]    gnt,
   output logic [1:0]    done,
   output logic [DW-1:0] rdata,
   output logic [7:0]    wait_cnt,
   output logic          trans,
   output logic          re_wr,
   output logic [AW-1:0] wr_paddr,
   output logic [AW-1:0] re_paddr,
   output logic [DW-1:0] wr_data,
   input  logic          psel,
   input  logic          pena,
   input  logic          pready,
   input  logic [DW-1:0] pdata
);

   typedef enum logic {S_IDLE, S_XFER} state_t;

   state_t        r_state;
   state_t        w_next;
   logic          w_cmpl;
   logic          w_grant;
   logic          w_win;
   logic          w_xfer;
   logic [1:0]    r_gnt;
   logic [1:0]    r_done;
   logic [DW-1:0] r_rdata;
   logic [7:0]    r_wait_cnt;
   logic [7:0]    r_wcnt;
   logic          r_wr;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_wdata;

   assign w_cmpl  = psel & pena & pready;
   assign w_xfer  = (r_state == S_XFER);
   assign w_grant = (r_state == S_IDLE) & (|req);

`ifdef APB_ARB_FIXED_PRIO_EN
   assign w_win = ~req[0];
`else
   logic r_last;

   // Contest goes to whoever did not win last; a lone requester always wins.
   assign w_win = (&req) ? ~r_last : req[1];

   always_ff @(posedge pclk) begin
      if (!preset)      r_last <= 1'b1;
      else if (w_grant) r_last <= w_win;
   end
`endif

   always_ff @(posedge pclk) begin
      if (!preset) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (|req)  w_next = S_XFER;
         S_XFER: if (w_cmpl) w_next = S_IDLE;
         default:           w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (!preset) begin
         r_gnt      <= '0;
         r_done     <= '0;
         r_rdata    <= '0;
         r_wait_cnt <= '0;
         r_wcnt     <= '0;
         r_wr       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
      end else begin
         r_done <= '0;
         if (w_grant) begin
            r_gnt   <= w_win ? 2'b10 : 2'b01;
            r_wr    <= req_wr[w_win];
            r_addr  <= w_win ? req_addr1 : req_addr0;
            r_wdata <= req_wr[w_win] ? (w_win ? req_wdata1 : req_wdata0) : '0;
            r_wcnt  <= '0;
         end else if (w_xfer) begin
            if (psel & pena & ~pready & (r_wcnt != 8'hFF))
               r_wcnt <= r_wcnt + 8'd1;
            // C has pready high, so r_wcnt is already final here.
            if (w_cmpl) begin
               if (!r_wr) r_rdata <= pdata;
               r_done     <= r_gnt;
               r_gnt      <= '0;
               r_wait_cnt <= r_wcnt;
            end
         end
      end
   end

   assign gnt      = r_gnt;
   assign done     = r_done;
   assign rdata    = r_rdata;
   assign wait_cnt = r_wait_cnt;
   assign trans    = w_xfer & ~w_cmpl;
   assign re_wr    = w_xfer & r_wr;
   assign wr_paddr = w_xfer ? r_addr  : '0;
   assign re_paddr = w_xfer ? r_addr  : '0;
   assign wr_data  = w_xfer ? r_wdata : '0;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter with a behavioural APB master model.
module tb_apb_req_arbiter;

   logic       pclk = 1'b0;
   logic       preset = 1'b0;
   logic [1:0] req = '0, req_wr = '0;
   logic [7:0] req_addr0 = '0, req_addr1 = '0, req_wdata0 = '0, req_wdata1 = '0;
   logic [1:0] gnt, done;
   logic [7:0] rdata, wait_cnt, wr_paddr, re_paddr, wr_data;
   logic       trans, re_wr;
   logic       psel, pena, pready;
   logic [7:0] pdata = '0;

   int n_chk = 0;
   int n_fail = 0;
   int n_waits = 0;

   apb_req_arbiter #(.AW(8), .DW(8)) dut (
      .pclk(pclk), .preset(preset), .req(req), .req_wr(req_wr),
      .req_addr0(req_addr0), .req_addr1(req_addr1),
      .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
      .gnt(gnt), .done(done), .rdata(rdata), .wait_cnt(wait_cnt),
      .trans(trans), .re_wr(re_wr), .wr_paddr(wr_paddr), .re_paddr(re_paddr),
      .wr_data(wr_data), .psel(psel), .pena(pena), .pready(pready), .pdata(pdata)
   );

   always #5 pclk = ~pclk;

   // APB master: 0 IDLE, 1 SETUP, 2 ACCESS; holds pready low for n_waits ACCESS cycles.
   logic [1:0] mst;
   int         acc_cnt;
   assign psel   = (mst != 2'd0);
   assign pena   = (mst == 2'd2);
   assign pready = (mst == 2'd2) && (acc_cnt >= n_waits);

   always @(posedge pclk) begin
      if (!preset) begin
         mst     <= 2'd0;
         acc_cnt <= 0;
      end else begin
         case (mst)
            2'd0: if (trans) mst <= 2'd1;
            2'd1: begin mst <= 2'd2; acc_cnt <= 0; end
            default: begin
               if (pready) mst <= trans ? 2'd1 : 2'd0;
               else        acc_cnt <= acc_cnt + 1;
            end
         endcase
      end
   end

   typedef struct {
      logic       client;
      logic       wr;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] pdata;
      int         nw;
      logic [7:0] exp_rdata;
      logic [7:0] exp_wcnt;
   } vec_t;

   vec_t vecs[5];
   vec_t sat;

   task automatic step();
      @(posedge pclk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      req    = '0;
      preset = 1'b0;
      step();
      step();
      preset = 1'b1;
   endtask

   // Call in an IDLE cycle (G); walks the transfer cycle by cycle to done.
   task automatic run_txn(input vec_t v, input string nm);
      logic [1:0] oh;
      int         total;
      oh    = v.client ? 2'b10 : 2'b01;
      total = 4 + v.nw;
      req_wr[v.client] = v.wr;
      if (v.client) begin req_addr1 = v.addr; req_wdata1 = v.wdata; end
      else          begin req_addr0 = v.addr; req_wdata0 = v.wdata; end
      pdata   = v.pdata;
      n_waits = v.nw;
      req[v.client] = 1'b1;
      for (int n = 1; n <= total; n++) begin
         step();
         chk({nm, "_gnt_done_trans"}, {27'd0, gnt, done, trans},
             {27'd0, (n <= 3 + v.nw) ? oh : 2'b00, (n == total) ? oh : 2'b00, 1'(n <= 2 + v.nw)});
         if (n == 1) begin
            chk({nm, "_re_wr"}, {31'd0, re_wr}, {31'd0, v.wr});
            chk({nm, "_wr_paddr"}, {24'd0, wr_paddr}, {24'd0, v.addr});
            chk({nm, "_re_paddr"}, {24'd0, re_paddr}, {24'd0, v.addr});
            chk({nm, "_wr_data"}, {24'd0, wr_data}, {24'd0, v.wr ? v.wdata : 8'h00});
         end
         if (n == total) begin
            req[v.client] = 1'b0;
            chk({nm, "_rdata"}, {24'd0, rdata}, {24'd0, v.exp_rdata});
            chk({nm, "_wait_cnt"}, {24'd0, wait_cnt}, {24'd0, v.exp_wcnt});
         end
      end
      step();
      chk({nm, "_after"}, {28'd0, gnt, done}, 32'd0);
   endtask

   initial begin
      logic [1:0] g_seen[4];
      int         t_seen[4];
      int         ng;
      logic [1:0] prev;
      logic [1:0] any_gnt;
      logic [1:0] exp_g;

      vecs[0] = '{client:1'b0, wr:1'b1, addr:8'h12, wdata:8'hA5, pdata:8'h77, nw:0, exp_rdata:8'h00, exp_wcnt:8'd0};
      vecs[1] = '{client:1'b1, wr:1'b0, addr:8'h40, wdata:8'h11, pdata:8'h3C, nw:3, exp_rdata:8'h3C, exp_wcnt:8'd3};
      vecs[2] = '{client:1'b0, wr:1'b0, addr:8'hFF, wdata:8'h00, pdata:8'hC3, nw:1, exp_rdata:8'hC3, exp_wcnt:8'd1};
      vecs[3] = '{client:1'b1, wr:1'b1, addr:8'h01, wdata:8'h5A, pdata:8'h99, nw:2, exp_rdata:8'hC3, exp_wcnt:8'd2};
      vecs[4] = '{client:1'b0, wr:1'b0, addr:8'h80, wdata:8'hFF, pdata:8'h00, nw:0, exp_rdata:8'h00, exp_wcnt:8'd0};
      sat     = '{client:1'b1, wr:1'b0, addr:8'h33, wdata:8'h00, pdata:8'h6E, nw:300, exp_rdata:8'h6E, exp_wcnt:8'hFF};

      // Reset state
      step();
      chk("reset_outs", {gnt, done, trans, re_wr, wr_paddr, re_paddr, wr_data, rdata}, 46'd0);
      chk("reset_wait_cnt", {24'd0, wait_cnt}, 32'd0);
      step();
      preset = 1'b1;

      foreach (vecs[i]) run_txn(vecs[i], $sformatf("vec%0d", i));
      run_txn(sat, "wait_sat");

      // Contention from reset
      do_reset();
      req_wr  = 2'b00;
      n_waits = 0;
      req     = 2'b11;
      prev    = '0;
      ng      = 0;
      for (int n = 1; n <= 16; n++) begin
         step();
         if (gnt != 2'b00 && prev == 2'b00 && ng < 4) begin
            g_seen[ng] = gnt;
            t_seen[ng] = n;
            ng++;
         end
         prev = gnt;
      end
      chk("contend_count", ng, 4);
      for (int i = 0; i < 4; i++) begin
`ifdef APB_ARB_FIXED_PRIO_EN
         exp_g = 2'b01;
`else
         exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
         if (i < ng) begin
            chk($sformatf("contend_gnt%0d", i), {30'd0, g_seen[i]}, {30'd0, exp_g});
            chk($sformatf("contend_time%0d", i), t_seen[i], 1 + 4 * i);
         end
      end

      // Early request drop
      do_reset();
      req_wr  = 2'b00;
      pdata   = 8'h4D;
      req     = 2'b10;
      step();
      chk("drop_gnt", {30'd0, gnt}, 32'd2);
      step();
      req = 2'b00;
      step();
      step();
      chk("drop_done", {30'd0, done}, 32'd2);
      chk("drop_rdata", {24'd0, rdata}, 32'h4D);
      any_gnt = '0;
      for (int n = 0; n < 4; n++) begin
         step();
         any_gnt |= gnt;
      end
      chk("drop_no_regrant", {30'd0, any_gnt}, 32'd0);

      // Reset mid-transfer
      do_reset();
      run_txn(vecs[2], "pre_abort");
      req_wr  = 2'b00;
      pdata   = 8'h55;
      req     = 2'b01;
      step();
      chk("abort_gnt", {30'd0, gnt}, 32'd1);
      step();
      preset = 1'b0;
      step();
      preset = 1'b1;
      chk("abort_outs", {gnt, done, trans, re_wr, wr_paddr, re_paddr, wr_data, rdata}, 46'd0);
      chk("abort_wait_cnt", {24'd0, wait_cnt}, 32'd0);
      req = 2'b11;
      step();
      chk("abort_regrant", {30'd0, gnt, done}, 32'h4);
      chk("abort_trans", {31'd0, trans}, 32'd1);
      do_reset();

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/apb_req_arbiter.md
# apb_req_arbiter

Two-client round-robin arbiter and sequencer in front of the APB master. Each client posts a single read or write command. The arbiter grants one client at a time and drives the master's `trans`/`re_wr`/address/data inputs. It watches `psel`/`pena`/`pready` for completion, then returns read data and a one-cycle `done` to the granted client. It is the only driver of the APB master's command inputs.

## Interface
- `AW`, default 8, address width (matches master `paddr`)
- `DW`, default 8, data width (matches master `pwr_data`/`pdata`)
- `pclk` in 1: clock, rising edge
- `preset` in 1: synchronous active-low reset
- `req` in 2: per-client request level; held until that client's `done`
- `req_wr` in 2: per-client direction, 1 = write, 0 = read
- `req_addr0`, `req_addr1` in AW each: client command address
- `req_wdata0`, `req_wdata1` in DW each: client write data
- `gnt` out 2: one-hot grant, high from grant edge through completion cycle
- `done` out 2: one-cycle pulse to the granted client, the cycle after completion
- `rdata` out DW: read data, valid while `done` is high, held until next completion
- `wait_cnt` out 8: `pready`-low ACCESS cycles of the last transfer, saturating at 255
- `trans` out 1: to master; request a transfer
- `re_wr` out 1: to master; direction of current transfer
- `wr_paddr`, `re_paddr` out AW each: to master; both carry the latched address
- `wr_data` out DW: to master; latched write data (0 for reads)
- `psel`, `pena`, `pready` in 1 each: observed APB control
- `pdata` in DW: APB read data

## Operation
- Two states: IDLE and XFER.
- **IDLE:**
  - If `req` is nonzero, select the winner, set `gnt`, latch `req_wr`/`req_addr`/`req_wdata` of the winner, and go to XFER.
  - Otherwise stay in IDLE.
- **XFER:** stay until the completion cycle C (`psel & pena & pready`), then return to IDLE.
- **Round-robin:**
  - `last` pointer names the most recent winner; reset value 1, so client 0 wins the first contest.
  - Both requesting: grant `~last`. One requesting: grant it.
  - `last` updates at every grant.
- **trans:** combinational, `trans = (state==XFER) & ~(psel & pena & pready)`.
  - It drops in cycle C, so the master returns to IDLE.
  - No back-to-back SETUP.
- **Command outputs:**
  - `re_wr`, `wr_paddr`, `re_paddr`, `wr_data` come from the latch registers.
  - They are stable throughout XFER.
  - They are 0 in IDLE.
- **Completion, at the edge ending C:**
  - If the transfer was a read, `rdata <= pdata`; writes leave `rdata` unchanged.
  - `done[gnt] <= 1` for one cycle.
  - `gnt <= 0`.
- **wait_cnt:**
  - An internal counter clears at grant.
  - It increments each XFER cycle with `psel & pena & ~pready`, saturating at 255.
  - It is copied to `wait_cnt` at completion.
- **Request edge cases:**
  - A `req` deassert during XFER is ignored; the transfer finishes and `done` still pulses.
  - `req` still high in the `done` cycle counts as a new request. It is eligible at that same edge, because IDLE arbitrates in the `done` cycle.
  - The command fields are sampled only at the grant edge.
- **Reset:** all outputs 0, state IDLE, `last` = 1, counters 0.
  - Reset mid-transfer aborts without a `done` pulse.
  - The master shares `preset` and also returns to IDLE.

## Timing
- Cycle G (IDLE with `req`) → XFER from G+1, `trans` = 1 from G+1.
- Master sequence: SETUP at G+2, ACCESS at G+3.
- Zero-wait transfer: C = G+3, `done` at G+4.
- Each `pready`-low ACCESS cycle adds one cycle of latency.
- Minimum grant-to-grant spacing: 4 cycles (G, G+4).
- `gnt` is high in G+1..C; `done` is high in C+1 only.

## Configuration
- `APB_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, client 0 always wins a contest, and the `last` pointer is not implemented.
  - Undefined (default): round-robin as above.

## Test plan
- **Single write:** client 0 writes, addr 0x12, data 0xA5, `pready` tied 1.
  - `trans` high G+1..G+2, then low in C = G+3.
  - `re_wr` = 1, `wr_paddr` = 0x12, `wr_data` = 0xA5.
  - `done[0]` at G+4, `wait_cnt` = 0.
- **Read with waits:** client 1 reads addr 0x40, `pready` low 3 ACCESS cycles, `pdata` = 0x3C.
  - `rdata` = 0x3C with `done[1]` at G+7, `wait_cnt` = 3.
- **Contention:** both clients request continuously from reset.
  - Grants alternate 0, 1, 0, 1, spaced 4 cycles apart.
  - With `APB_ARB_FIXED_PRIO_EN`: 0, 0, 0.
- **Early request drop:** `req` dropped in G+2.
  - The transfer still completes and `done` pulses.
  - No second grant follows.
- **Reset mid-transfer:** `preset` low in G+2 for 1 cycle.
  - Next cycle all outputs are 0, no `done`.
  - After reset, client 0 wins a contest.
- **Wait saturation:** `pready` low 300 cycles → `wait_cnt` = 255.
